// File: rtl/pp_accumulate_normalizer.sv
// rtl/pp_accumulate_normalizer.sv - exact partial-product accumulator, normalised/rounded to S|E5|M2
// Define PPACC_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module pp_accumulate_normalizer #(
  parameter int ACC_W    = 48,
  parameter int PP_BIAS  = 15,
  parameter int IMG_BIAS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_pp,
  input  logic [5:0] in_exp,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_image
);
  localparam int PW = $clog2(ACC_W);
  localparam logic signed [9:0] E_OFF = 10'(IMG_BIAS - PP_BIAS - 2);

  typedef enum logic [1:0] {ST_ACC, ST_NORM, ST_OUT} state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [7:0]              out_image_q;
  logic [7:0]              image_d;

  logic [ACC_W-1:0]        term;
  logic [ACC_W-1:0]        mag;
  logic                    sign;
  logic [PW-1:0]           p;
  logic [1:0]              m;
  logic                    round_up;
  logic [2:0]              mant_r;
  logic signed [9:0]       e_raw;
  logic signed [9:0]       e_rnd;

  assign term  = ACC_W'(in_pp[2:0]) << in_exp;
  assign acc_d = in_pp[3] ? acc_q - term : acc_q + term;

  assign sign = acc_q[ACC_W-1];
  assign mag  = sign ? ACC_W'(-acc_q) : ACC_W'(acc_q);

  always_comb begin
    p = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) p = PW'(i);
    end
  end

`ifdef PPACC_RNE_EN
  // ext >> p places the leading one at bit 3, so the low 3 bits are {M, guard}
  logic [ACC_W+2:0] ext;
  logic [2:0]       mg;
  logic             sticky;
  assign ext      = {mag, 3'b000};
  assign mg       = 3'(ext >> p);
  assign m        = mg[2:1];
  assign sticky   = |(ext & ~({(ACC_W+3){1'b1}} << p));
  assign round_up = mg[0] & (sticky | mg[1]);
`else
  logic [ACC_W+1:0] ext;
  assign ext      = {mag, 2'b00};
  assign m        = 2'(ext >> p);
  assign round_up = 1'b0;
`endif

  assign mant_r = {1'b0, m} + {2'b00, round_up};
  assign e_raw  = $signed(10'(p)) + E_OFF;
  assign e_rnd  = e_raw + $signed({9'd0, mant_r[2]});

  always_comb begin
    image_d = 8'h00;
    if (acc_q == '0) begin
      image_d = 8'h00;
    end else if (e_rnd > 10'sd30) begin
      image_d = {sign, 5'd30, 2'b11};
    end else if (e_rnd < 10'sd1) begin
      image_d = {sign, 7'd0};
    end else begin
      image_d = {sign, e_rnd[4:0], mant_r[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_image_q <= 8'h00;
    end else begin
      case (state_q)
        ST_ACC: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            acc_q <= acc_d;
            if (in_last) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          out_image_q <= image_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_image = out_image_q;

endmodule
